// File: rtl/gmsk_burst_feeder.sv
// Symbol source for the GMSK modulator. Frames payload bits into a normal burst
// (head tail, payload, tail, guard), differentially encodes them and paces sampling.
module gmsk_burst_feeder #(
  parameter int unsigned PAYLOAD_BITS = 142,
  parameter int unsigned TAIL_BITS    = 3,
  parameter int unsigned GUARD_BITS   = 8,
  parameter int unsigned SAMPLE_DIV   = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic burst_start,
  output logic start_ready,
  input  logic bit_in,
  input  logic bit_valid,
  output logic bit_ready,
  input  logic next_symbol_strobe,
  output logic sample_strobe,
  output logic current_symbol,
  output logic burst_active,
  output logic underflow
);

  localparam int unsigned MaxBits =
      (PAYLOAD_BITS > GUARD_BITS) ?
      ((PAYLOAD_BITS > TAIL_BITS) ? PAYLOAD_BITS : TAIL_BITS) :
      ((GUARD_BITS > TAIL_BITS) ? GUARD_BITS : TAIL_BITS);
  localparam int unsigned CntW = $clog2(MaxBits + 1);
  localparam int unsigned DivW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  localparam logic [CntW-1:0] TailLast    = CntW'(TAIL_BITS - 1);
  localparam logic [CntW-1:0] PayloadLast = CntW'(PAYLOAD_BITS - 1);
  localparam logic [CntW-1:0] GuardLast   = CntW'(GUARD_BITS - 1);
  localparam logic [DivW-1:0] DivLast     = DivW'(SAMPLE_DIV - 1);

  typedef enum logic [2:0] {StIdle, StHead, StPayload, StTail, StGuard} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DivW-1:0] div_q;
  logic            pending_q, pending_d;
  logic            underflow_q, underflow_d;
  logic            symbol_q, symbol_d;
  logic            prev_raw_q, prev_raw_d;
  logic            active_q, active_d;
  logic            strobe_q;
  logic            adv;
  logic            start_accept;
  logic            raw;

  assign adv          = next_symbol_strobe & ~strobe_q;
  assign start_ready  = (state_q == StIdle) | ((state_q == StGuard) & (cnt_q == GuardLast));
  assign start_accept = burst_start & start_ready;
  // A bit held back by reset is never consumed.
  assign bit_ready    = reset_n & adv & (state_q == StPayload) & bit_valid;

  assign sample_strobe  = (div_q == DivLast);
  assign current_symbol = symbol_q;
  assign burst_active   = active_q;
  assign underflow      = underflow_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pending_d   = pending_q;
    underflow_d = underflow_q;
    raw         = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (start_accept) begin
          state_d = StHead;
          cnt_d   = '0;
        end
      end
      StHead: begin
        raw = 1'b0;
        if (adv) begin
          if (cnt_q == TailLast) begin
            state_d = StPayload;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StPayload: begin
        raw = bit_valid & bit_in;
        if (adv) begin
          if (!bit_valid) underflow_d = 1'b1;
          if (cnt_q == PayloadLast) begin
            state_d = StTail;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StTail: begin
        raw = 1'b0;
        if (adv) begin
          if (cnt_q == TailLast) begin
            state_d = StGuard;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StGuard: begin
        if (start_accept) pending_d = 1'b1;
        if (adv) begin
          if (cnt_q == GuardLast) begin
            // A start taken during the last guard symbol chains straight into the next head.
            state_d   = (pending_q | start_accept) ? StHead : StIdle;
            cnt_d     = '0;
            pending_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: begin
        state_d   = StIdle;
        cnt_d     = '0;
        pending_d = 1'b0;
      end
    endcase

    symbol_d   = symbol_q;
    prev_raw_d = prev_raw_q;
    active_d   = active_q;
    if (adv) begin
      symbol_d   = raw ^ prev_raw_q;
      prev_raw_d = raw;
      active_d   = (state_q == StHead) | (state_q == StPayload) | (state_q == StTail);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      div_q       <= '0;
      pending_q   <= 1'b0;
      underflow_q <= 1'b0;
      symbol_q    <= 1'b0;
      prev_raw_q  <= 1'b1;
      active_q    <= 1'b0;
      strobe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= (div_q == DivLast) ? '0 : div_q + DivW'(1);
      pending_q   <= pending_d;
      underflow_q <= underflow_d;
      symbol_q    <= symbol_d;
      prev_raw_q  <= prev_raw_d;
      active_q    <= active_d;
      strobe_q    <= next_symbol_strobe;
    end
  end

endmodule

// File: tb/tb_gmsk_burst_feeder.sv
// Scoreboard bench for gmsk_burst_feeder: stimulus queues hand-derived symbols,
// a negedge monitor pops them one clock after each symbol request edge.
module tb_gmsk_burst_feeder;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic burst_start = 1'b0;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic next_symbol_strobe = 1'b0;
  logic start_ready, bit_ready, sample_strobe, current_symbol, burst_active, underflow;

  typedef struct packed {
    logic sym;
    logic act;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   br_count = 0;
  int   since = 0;
  logic nss_last = 1'b0;
  logic chk_pending = 1'b0;
  logic last_sym = 1'b0;
  logic last_act = 1'b0;

  always #5 clock = ~clock;

  gmsk_burst_feeder dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .burst_start        (burst_start),
    .start_ready        (start_ready),
    .bit_in             (bit_in),
    .bit_valid          (bit_valid),
    .bit_ready          (bit_ready),
    .next_symbol_strobe (next_symbol_strobe),
    .sample_strobe      (sample_strobe),
    .current_symbol     (current_symbol),
    .burst_active       (burst_active),
    .underflow          (underflow)
  );

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s at %0t: got %0d want %0d", name, $time, got, want);
    end
  endtask

  // Symbol monitor: new symbol one clock after a request edge, otherwise outputs hold.
  always @(negedge clock) begin
    if (!reset_n) begin
      chk_pending = 1'b0;
      nss_last    = 1'b0;
      last_sym    = 1'b0;
      last_act    = 1'b0;
    end else begin
      if (chk_pending) begin
        if (exp_q.size() == 0) begin
          check_int("sb_underrun", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check_bit("symbol", current_symbol, mon_e.sym);
          check_bit("burst_active", burst_active, mon_e.act);
          last_sym = mon_e.sym;
          last_act = mon_e.act;
        end
      end else begin
        check_bit("symbol_hold", current_symbol, last_sym);
        check_bit("active_hold", burst_active, last_act);
      end
      if (bit_ready) br_count++;
      chk_pending = next_symbol_strobe & ~nss_last;
      nss_last    = next_symbol_strobe;
    end
  end

  // Sample strobe period, measured from reset release.
  always @(negedge clock) begin
    if (!reset_n) begin
      since = 0;
    end else begin
      since++;
      if (sample_strobe) begin
        check_int("strobe_period", since, 16);
        since = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Hand-derived symbols for burst position n (3 head, 142 payload, 3 tail, 8 guard).
  // kind 0: payload all ones; kind 1: alternating 1,0,..; kind 2: ones with raw 0 at p=9..11.
  function automatic exp_t burst_exp(input int kind, input int n);
    exp_t e;
    int   p;
    p     = n - 3;
    e.act = (n < 148);
    if (n < 3) begin
      e.sym = (n == 0);
    end else if (n < 145) begin
      if (kind == 0)      e.sym = (p == 0);
      else if (kind == 1) e.sym = 1'b1;
      else                e.sym = (p == 0) || (p == 9) || (p == 12);
    end else if (n < 148) begin
      e.sym = (n == 145) ? (kind != 1) : 1'b0;
    end else begin
      e.sym = (n == 148);
    end
    return e;
  endfunction

  task automatic adv(input exp_t e, input int hold);
    exp_q.push_back(e);
    next_symbol_strobe = 1'b1;
    repeat (hold) @(posedge clock);
    #1 next_symbol_strobe = 1'b0;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic burst_span(input int kind, input int from, input int to);
    int p;
    for (int n = from; n <= to; n++) begin
      p         = n - 3;
      bit_valid = !((kind == 2) && (p >= 9) && (p <= 11));
      bit_in    = (kind == 1) ? ~p[0] : 1'b1;
      adv(burst_exp(kind, n), ((n == 0) && (kind == 0)) ? 5 : 1);
    end
  endtask

  task automatic pulse_start();
    burst_start = 1'b1;
    @(posedge clock);
    #1 burst_start = 1'b0;
  endtask

  initial begin
    repeat (4) @(posedge clock);
    #1 reset_n = 1'b1;
    check_bit("rst_start_ready", start_ready, 1'b1);
    check_bit("rst_symbol", current_symbol, 1'b0);
    check_bit("rst_active", burst_active, 1'b0);
    check_bit("rst_underflow", underflow, 1'b0);
    check_bit("rst_bit_ready", bit_ready, 1'b0);
    check_bit("rst_sample_strobe", sample_strobe, 1'b0);

    for (int i = 0; i < 64; i++) adv(exp_t'(2'b00), 1);

    // All-ones payload; first head request held for 5 clocks.
    check_bit("a_start_ready", start_ready, 1'b1);
    br_count = 0;
    pulse_start();
    burst_span(0, 0, 155);
    check_int("a_bit_ready_count", br_count, 142);
    check_bit("a_underflow", underflow, 1'b0);

    // Alternating payload.
    br_count = 0;
    pulse_start();
    burst_span(1, 0, 155);
    check_int("b_bit_ready_count", br_count, 142);
    check_bit("b_underflow", underflow, 1'b0);

    // Payload symbols 10-12 starved.
    br_count = 0;
    pulse_start();
    burst_span(2, 0, 155);
    check_int("c_bit_ready_count", br_count, 139);
    check_bit("c_underflow", underflow, 1'b1);

    // Start mid-payload is ignored; start in last guard chains a new burst.
    br_count = 0;
    pulse_start();
    burst_span(0, 0, 19);
    check_bit("d_start_ready_mid", start_ready, 1'b0);
    pulse_start();
    burst_span(0, 20, 154);
    check_bit("d_start_ready_last_guard", start_ready, 1'b1);
    pulse_start();
    burst_span(0, 155, 155);
    check_int("d_bit_ready_count", br_count, 142);

    // Chained burst, reset after payload symbol 50.
    br_count = 0;
    burst_span(0, 0, 52);
    check_int("e_bit_ready_count", br_count, 50);
    check_bit("e_underflow_sticky", underflow, 1'b1);
    reset_n = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    check_bit("mid_rst_symbol", current_symbol, 1'b0);
    check_bit("mid_rst_start_ready", start_ready, 1'b1);
    check_bit("mid_rst_active", burst_active, 1'b0);
    check_bit("mid_rst_underflow", underflow, 1'b0);
    br_count  = 0;
    bit_valid = 1'b1;
    for (int i = 0; i < 4; i++) adv(exp_t'(2'b00), 1);
    check_int("post_rst_bit_ready_count", br_count, 0);

    repeat (3) @(posedge clock);
    #1;
    check_int("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
